pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter unit for the multicycle CPU: holds the architectural PC register and computes the next PC from the relative-branch, absolute-jump, register-jump, exception, exception-return and predicted-return sources. It owns the EPC register and an exception-level (EXL) flag, and, when configured in, a circular return-address stack (RAS) that serves `jr $ra` returns. It sits between the control FSM, which asserts `pc_we` once per instruction at the PC-update state, and the instruction-fetch address path.

## Interface
- XLEN, 32, PC/data width (≥ 28+4; abs jump keeps pc[XLEN-1:28])
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VEC, 32'h0000_4180, exception entry address
- RAS_DEPTH, 4, RAS entries (power of two, ≥ 2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_we  in  1  commit: load pc_next into pc this edge
- npc_op  in  3  next-PC source select (see Operation)
- link  in  1  with op 010/011: instruction writes a return address (jal/jalr); push pc+4
- imm16  in  16  branch offset, in words
- imm26  in  26  absolute jump target field
- rs_val  in  XLEN  register-jump target
- exc_req  in  1  exception request, sampled with pc_we
- pc  out  XLEN  current PC (registered)
- pc_next  out  XLEN  combinational next-PC candidate
- epc  out  XLEN  saved exception PC (registered)
- exl  out  1  exception level flag
- ras_empty, ras_full  out  1  RAS occupancy flags
- ras_miss  out  1  1-cycle pulse: op 110 committed with empty RAS
- misalign  out  1  combinational: pc_next[1:0] != 0

## Operation
- npc_op decode: 000 pc+4; 001 pc+4+sext(imm16,2'b00); 010 {pc[XLEN-1:28],imm26,2'b00}; 011 rs_val; 100 EXC_VEC; 101 epc (eret); 110 RAS top (predicted return); 111 reserved = pc+4.
- All additions modulo 2^XLEN; wrap-around not flagged.
- Branch base is pc+4; pc is never updated between fetch and commit.
- Exception: exc_req=1 and exl=0 forces pc_next=EXC_VEC regardless of npc_op; on pc_we: epc<=pc, exl<=1, no RAS push/pop.
- exc_req while exl=1 is ignored (npc_op honoured); no nested EPC overwrite.
- op 101 on pc_we: pc<=epc, exl<=0.
- RAS push: pc_we & link & op∈{010,011} & exception not taken → top<=pc+4; count=min(count+1,RAS_DEPTH); when full, the oldest entry is overwritten (circular pointer wraps).
- RAS pop: pc_we & op 110 & not empty → pc<=top, count-1. Empty: pc_next=rs_val, no pointer change, ras_miss pulses for one cycle.
- pc_next is the value pc would take; without pc_we no state changes (pc, epc, exl, RAS all hold).
- misalign is advisory only; pc loads the unaligned value unchanged.

## Timing
- Reset (rst high at edge): pc=RESET_PC, epc=0, exl=0, RAS count=0 and pointer=0, ras_empty=1, ras_full=0, ras_miss=0. Reset overrides pc_we and exc_req in the same cycle.
- pc_next, misalign: combinational from pc, npc_op, inputs, epc, RAS top; no cycle of latency.
- pc/epc/exl/RAS update one edge after pc_we sampled high; visible next cycle.
- ras_miss registered: high exactly the cycle after the offending commit.
- RAS state: one of {EMPTY, PARTIAL, FULL} from count; EMPTY→PARTIAL on push, PARTIAL→FULL at count=RAS_DEPTH, FULL stays FULL on push (overwrite), any→lower on pop.
- Reset mid-sequence discards RAS contents and EXL; no partial commit.

## Configuration
- PCGEN_RAS_EN defined: RAS built as above.
- Undefined: no RAS storage; op 110 behaves exactly as 011 (pc_next=rs_val); link ignored; ras_empty=1, ras_full=0, ras_miss=0 constant.

## Test plan
- Reset then 3 commits of op 000 → pc 0x3000, 0x3004, 0x3008, 0x300C; epc=0, exl=0.
- pc=0x3010, op 001, imm16=0xFFFE → pc_next=0x300C; op 010, imm26=0x0000C40 → pc_next=0x00003100.
- pc=0x3020, exc_req with op 001 → pc=0x4180, epc=0x3020, exl=1; second exc_req with op 000 → pc=0x4184, epc unchanged; op 101 → pc=0x3020, exl=0.
- RAS_DEPTH=4: 5 jal (op 010, link) from pc 0x3000,0x3100,0x3200,0x3300,0x3400 → ras_full=1; 4 pops return 0x3404,0x3304,0x3204,0x3104 then ras_empty=1.
- Pop on empty RAS with rs_val=0x3ABC → pc=0x3ABC, ras_miss high one cycle; op 011 rs_val=0x3001 → misalign=1, pc loads 0x3001.
- Without PCGEN_RAS_EN: op 110, rs_val=0x3200 → pc=0x3200, ras_miss stays 0.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter unit: PC/EPC/EXL registers and next-PC selection.
// Optional return-address stack enabled with `define PCGEN_RAS_EN.
module pc_gen #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [XLEN-1:0] EXC_VEC  = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_we,
  input  logic [2:0]      npc_op,
  input  logic            link,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [XLEN-1:0] rs_val,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc,
  output logic            exl,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_miss,
  output logic            misalign
);

  logic [XLEN-1:0] pc_q, pc_d, epc_q;
  logic            exl_q;
  logic            exc_take;
  logic [XLEN-1:0] pc_plus4, br_off, j_abs, ret_tgt;

  assign exc_take = exc_req & ~exl_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_off   = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign j_abs    = {pc_q[XLEN-1:28], imm26, 2'b00};

`ifdef PCGEN_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {RAS_EMPTY, RAS_PARTIAL, RAS_FULL} ras_state_e;

  logic [XLEN-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     cnt_q;
  ras_state_e      st_q;
  logic            miss_q;
  logic            push, pop, miss_d;

  // ptr_q addresses the next free slot; top of stack sits one below it.
  assign ret_tgt = (st_q == RAS_EMPTY) ? rs_val : stack_q[ptr_q - PW'(1)];
  assign push    = pc_we & link & ~exc_take & ((npc_op == 3'b010) | (npc_op == 3'b011));
  assign pop     = pc_we & ~exc_take & (npc_op == 3'b110) & (st_q != RAS_EMPTY);
  assign miss_d  = pc_we & ~exc_take & (npc_op == 3'b110) & (st_q == RAS_EMPTY);

  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_q] <= pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      st_q   <= RAS_EMPTY;
      miss_q <= 1'b0;
    end else begin
      miss_q <= miss_d;
      if (push) begin
        ptr_q <= ptr_q + PW'(1);
        if (cnt_q != DEPTH_C) cnt_q <= cnt_q + (PW+1)'(1);
        st_q  <= (cnt_q + (PW+1)'(1) >= DEPTH_C) ? RAS_FULL : RAS_PARTIAL;
      end else if (pop) begin
        ptr_q <= ptr_q - PW'(1);
        cnt_q <= cnt_q - (PW+1)'(1);
        st_q  <= (cnt_q == (PW+1)'(1)) ? RAS_EMPTY : RAS_PARTIAL;
      end
    end
  end

  assign ras_empty = (st_q == RAS_EMPTY);
  assign ras_full  = (st_q == RAS_FULL);
  assign ras_miss  = miss_q;
`else
  logic unused_link;
  assign unused_link = link;
  assign ret_tgt   = rs_val;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_miss  = 1'b0;
`endif

  always_comb begin
    pc_d = pc_plus4;
    if (exc_take) begin
      pc_d = EXC_VEC;
    end else begin
      unique case (npc_op)
        3'b000:  pc_d = pc_plus4;
        3'b001:  pc_d = pc_plus4 + br_off;
        3'b010:  pc_d = j_abs;
        3'b011:  pc_d = rs_val;
        3'b100:  pc_d = EXC_VEC;
        3'b101:  pc_d = epc_q;
        3'b110:  pc_d = ret_tgt;
        default: pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      exl_q <= 1'b0;
    end else if (pc_we) begin
      pc_q <= pc_d;
      if (exc_take) begin
        epc_q <= pc_q;
        exl_q <= 1'b1;
      end else if (npc_op == 3'b101) begin
        exl_q <= 1'b0;
      end
    end
  end

  assign pc       = pc_q;
  assign pc_next  = pc_d;
  assign epc      = epc_q;
  assign exl      = exl_q;
  assign misalign = |pc_d[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen against a queue-based behavioural model,
// plus directed literal checks of the PC, exception and RAS scenarios.
module tb_pc_gen;

`ifdef PCGEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam logic [31:0] EXC = 32'h0000_4180;
  localparam int RDEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1, pc_we = 1'b0, link = 1'b0, exc_req = 1'b0;
  logic [2:0]  npc_op = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] pc, pc_next, epc;
  logic        exl, ras_empty, ras_full, ras_miss, misalign;

  pc_gen #(.XLEN(32), .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .npc_op(npc_op), .link(link),
    .imm16(imm16), .imm26(imm26), .rs_val(rs_val), .exc_req(exc_req),
    .pc(pc), .pc_next(pc_next), .epc(epc), .exl(exl),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int unsigned npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model
  logic [31:0] m_pc, m_epc;
  bit          m_exl, m_miss, m_valid = 1'b0;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] m_next();
    if (exc_req && !m_exl) return EXC;
    case (npc_op)
      3'd1: return m_pc + 32'd4 + 32'(int'($signed(imm16)) * 4);
      3'd2: return (m_pc & 32'hF000_0000) | (32'(imm26) << 2);
      3'd3: return rs_val;
      3'd4: return EXC;
      3'd5: return m_epc;
      3'd6: return (RAS_ON && m_ras.size() > 0) ? m_ras[$] : rs_val;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] nx;
    bit taken;
    nx = m_next();
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("exl", 32'(exl), 32'(m_exl));
      chk("pc_next", pc_next, nx);
      chk("misalign", 32'(misalign), 32'(nx[1:0] != 2'b00));
      chk("ras_empty", 32'(ras_empty), 32'(!RAS_ON || m_ras.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(RAS_ON && m_ras.size() == RDEPTH));
      chk("ras_miss", 32'(ras_miss), 32'(m_miss));
    end
    if (rst) begin
      m_pc = 32'h0000_3000; m_epc = '0; m_exl = 1'b0; m_miss = 1'b0;
      m_ras.delete();
      m_valid = 1'b1;
    end else begin
      m_miss = 1'b0;
      if (pc_we) begin
        taken = exc_req && !m_exl;
        if (taken) begin
          m_epc = m_pc;
          m_exl = 1'b1;
        end else begin
          if (npc_op == 3'd5) m_exl = 1'b0;
          if (RAS_ON && link && (npc_op == 3'd2 || npc_op == 3'd3)) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > RDEPTH) m_ras.pop_front();
          end
          if (npc_op == 3'd6) begin
            if (RAS_ON && m_ras.size() > 0) void'(m_ras.pop_back());
            else m_miss = RAS_ON;
          end
        end
        m_pc = nx;
      end
    end
  end

  task automatic drive(input bit we, input logic [2:0] op, input bit lk, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs, input bit ex, input bit r);
    @(posedge clk); #1;
    pc_we = we; npc_op = op; link = lk; imm16 = i16; imm26 = i26; rs_val = rs; exc_req = ex; rst = r;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pc_we = 1'b0; exc_req = 1'b0; link = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [25:0] tgts[5];
    logic [31:0] rets[4];
    tgts = '{26'hC40, 26'hC80, 26'hCC0, 26'hD00, 26'hC00};
    rets = '{32'h3404, 32'h3304, 32'h3204, 32'h3104};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_epc", epc, 32'h0);
    chk("reset_exl", 32'(exl), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 3'd0, 0, 0, 0, 0, 0, 0); idle();
      chk("seq_pc", pc, 32'h3000 + 32'(4 * i));
    end
    drive(1, 3'd0, 0, 0, 0, 0, 0, 0); idle();
    drive(0, 3'd1, 0, 16'hFFFE, 0, 0, 0, 0); #1;
    chk("branch_back", pc_next, 32'h300C);
    drive(0, 3'd2, 0, 0, 26'h0000C40, 0, 0, 0); #1;
    chk("jump_abs", pc_next, 32'h3100);

    drive(1, 3'd3, 0, 0, 0, 32'h3020, 0, 0); idle();
    drive(1, 3'd1, 0, 16'h0010, 0, 0, 1, 0); idle();
    chk("exc_pc", pc, 32'h4180);
    chk("exc_epc", epc, 32'h3020);
    chk("exc_exl", 32'(exl), 32'h1);
    drive(1, 3'd0, 0, 0, 0, 0, 1, 0); idle();
    chk("nested_pc", pc, 32'h4184);
    chk("nested_epc", epc, 32'h3020);
    drive(1, 3'd5, 0, 0, 0, 0, 0, 0); idle();
    chk("eret_pc", pc, 32'h3020);
    chk("eret_exl", 32'(exl), 32'h0);

`ifdef PCGEN_RAS_EN
    drive(1, 3'd3, 0, 0, 0, 32'h3000, 0, 0); idle();
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd2, 1, 0, tgts[k], 0, 0, 0); idle();
    end
    chk("ras_full_after5", 32'(ras_full), 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'd6, 0, 0, 0, 32'h0, 0, 0); idle();
      chk("ras_pop", pc, rets[k]);
    end
    chk("ras_empty_after4", 32'(ras_empty), 32'h1);
`else
    drive(1, 3'd6, 0, 0, 0, 32'h3200, 0, 0); idle();
    chk("noras_ret", pc, 32'h3200);
    chk("noras_miss", 32'(ras_miss), 32'h0);
`endif
    drive(1, 3'd6, 0, 0, 0, 32'h3ABC, 0, 0); idle();
    chk("empty_pop_pc", pc, 32'h3ABC);
    chk("empty_pop_miss", 32'(ras_miss), 32'(RAS_ON));
    idle();
    chk("miss_one_cycle", 32'(ras_miss), 32'h0);
    drive(1, 3'd3, 0, 0, 0, 32'h3001, 0, 0); #1;
    chk("misalign_flag", 32'(misalign), 32'h1);
    idle();
    chk("misalign_load", pc, 32'h3001);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rs;
      rs = $urandom();
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            16'($urandom()), 26'($urandom()), rs, $urandom_range(0, 7) == 0,
            $urandom_range(0, 299) == 0);
    end
    idle();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
